// File: rtl/mealy_serial_feeder.sv
// Parallel-to-serial feeder for the sequence-detector FSMs: valid/ready word intake,
// one-word holding buffer, one serial bit per enabled clock, zero-gap back-to-back words.
module mealy_serial_feeder #(
  parameter int unsigned DATA_W    = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter bit          IDLE_BIT  = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              bit_en,
  output logic              dout,
  output logic              dout_valid,
  output logic              frame_start,
  output logic              busy
);

  localparam int unsigned CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t             state;
  logic [DATA_W-1:0]  sh;
  logic [DATA_W-1:0]  hold;
  logic               hold_full;
  logic [CNT_W-1:0]   cnt;
  logic [DATA_W-1:0]  sh_next;
  logic               accept;

  assign sh_next = MSB_FIRST ? {sh[DATA_W-2:0], 1'b0} : {1'b0, sh[DATA_W-1:1]};
  assign accept  = in_valid & in_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      sh        <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      cnt       <= '0;
    end else begin
      // accept only when hold is empty, so it never collides with a hold transfer
      if (accept) begin
        hold      <= in_data;
        hold_full <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (hold_full) begin
            sh        <= hold;
            hold_full <= 1'b0;
            cnt       <= '0;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          if (bit_en) begin
            if (cnt == LAST) begin
              if (hold_full) begin
                sh        <= hold;
                hold_full <= 1'b0;
              end else begin
                state <= IDLE;
              end
              cnt <= '0;
            end else begin
              sh  <= sh_next;
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // outputs decode flops only; in_ready also drops immediately with reset
  assign in_ready    = reset & ~hold_full;
  assign dout_valid  = (state == SHIFT);
  assign dout        = dout_valid ? (MSB_FIRST ? sh[DATA_W-1] : sh[0]) : IDLE_BIT;
  assign frame_start = dout_valid & (cnt == '0);
  assign busy        = dout_valid | hold_full;

endmodule

// File: tb/tb_mealy_serial_feeder.sv
// Bench for mealy_serial_feeder: MSB-first/idle-0 and LSB-first/idle-1 instances share
// stimulus; a word/bit-index reference model is compared every cycle, plus vector tables.
module tb_mealy_serial_feeder;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       bit_en;
  logic [1:0] o_rdy, o_dout, o_dv, o_fs, o_busy;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  mealy_serial_feeder #(.DATA_W(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut0 (
    .clk(clk), .reset(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(o_rdy[0]),
    .bit_en(bit_en), .dout(o_dout[0]), .dout_valid(o_dv[0]), .frame_start(o_fs[0]),
    .busy(o_busy[0]));

  mealy_serial_feeder #(.DATA_W(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) dut1 (
    .clk(clk), .reset(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(o_rdy[1]),
    .bit_en(bit_en), .dout(o_dout[1]), .dout_valid(o_dv[1]), .frame_start(o_fs[1]),
    .busy(o_busy[1]));

  function automatic bit msb(input int i);  return (i == 0); endfunction
  function automatic bit idle(input int i); return (i == 1); endfunction

  task automatic chk(input string nm, input int idx, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s[%0d] at %0t: got %h expected %h", nm, idx, $time, a, e);
    end
  endtask

  // Reference model: current word plus index of the bit on the line, and a one-word buffer.
  logic [7:0] m_cur [2];
  logic [7:0] m_hv  [2];
  int         m_pos [2];
  logic       m_act [2];
  logic       m_hf  [2];

  function automatic logic m_loads(input int i);
    return m_hf[i] && (!m_act[i] || (bit_en && m_pos[i] == 7));
  endfunction

  always @(posedge clk or negedge rst) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst) begin
        m_cur[i] <= '0; m_hv[i] <= '0; m_pos[i] <= 0; m_act[i] <= 1'b0; m_hf[i] <= 1'b0;
      end else begin
        if (m_loads(i)) begin
          m_cur[i] <= m_hv[i];
          m_pos[i] <= 0;
          m_act[i] <= 1'b1;
        end else if (m_act[i] && bit_en) begin
          if (m_pos[i] == 7) begin
            m_act[i] <= 1'b0;
            m_pos[i] <= 0;
          end else begin
            m_pos[i] <= m_pos[i] + 1;
          end
        end
        if (in_valid && !m_hf[i]) begin
          m_hv[i] <= in_data;
          m_hf[i] <= 1'b1;
        end else if (m_loads(i)) begin
          m_hf[i] <= 1'b0;
        end
      end
    end
  end

  function automatic logic m_dout(input int i);
    if (!m_act[i]) return idle(i);
    return msb(i) ? m_cur[i][7 - m_pos[i]] : m_cur[i][m_pos[i]];
  endfunction

  always @(negedge clk) begin
    if (chk_on) begin
      for (int i = 0; i < 2; i++) begin
        chk("dout", i, 64'(o_dout[i]), 64'(m_dout(i)));
        chk("dout_valid", i, 64'(o_dv[i]), 64'(m_act[i]));
        chk("frame_start", i, 64'(o_fs[i]), 64'(m_act[i] && m_pos[i] == 0));
        chk("busy", i, 64'(o_busy[i]), 64'(m_act[i] || m_hf[i]));
        chk("in_ready", i, 64'(o_rdy[i]), 64'(rst && !m_hf[i]));
      end
    end
  end

  // Capture results (per instance)
  logic [63:0] sr [2];
  logic [63:0] fsm [2];
  int nb [2], vc [2], first [2], last [2], lastbusy [2];

  // Called at posedge+1; holds in_valid through back-to-back words.
  task automatic send_seq(input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2,
                          input int n);
    bit ok, r;
    for (int k = 0; k < n; k++) begin
      in_data  = (k == 0) ? w0 : (k == 1) ? w1 : w2;
      in_valid = 1'b1;
      ok = 1'b0;
      for (int t = 0; t < 60 && !ok; t++) begin
        @(negedge clk); r = o_rdy[0];
        @(posedge clk); #1;
        if (r) ok = 1'b1;
      end
      chk("accept_timeout", k, 64'(ok), 64'(1));
    end
    in_valid = 1'b0;
  endtask

  task automatic collect(input int ncyc, input bit tog);
    bit seen = 1'b0;
    for (int i = 0; i < 2; i++) begin
      sr[i] = '0; fsm[i] = '0; nb[i] = 0; vc[i] = 0; first[i] = -1; last[i] = -1; lastbusy[i] = -1;
    end
    for (int c = 0; c < ncyc; c++) begin
      if (tog) begin
        if (!seen && o_fs[0]) begin bit_en = 1'b0; seen = 1'b1; end
        else if (seen) bit_en = ~bit_en;
        else bit_en = 1'b1;
      end else begin
        bit_en = 1'b1;
      end
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (o_dv[i]) begin
          vc[i]++;
          if (first[i] < 0) first[i] = c;
          last[i] = c;
          if (o_fs[i]) fsm[i][nb[i]] = 1'b1;
          if (bit_en) begin
            sr[i] = {sr[i][62:0], o_dout[i]};
            nb[i]++;
          end
        end
        if (o_busy[i]) lastbusy[i] = c;
      end
      @(posedge clk); #1;
    end
    bit_en = 1'b1;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int t = 0; t < 80 && !ok; t++) begin
      @(negedge clk);
      if (o_busy == 2'b00) ok = 1'b1;
      @(posedge clk); #1;
    end
    chk("idle_timeout", 0, 64'(ok), 64'(1));
  endtask

  typedef struct {
    logic [7:0] d;
    bit         tog;
    logic [7:0] e_msb;
    logic [7:0] e_lsb;
    int         e_vc;
  } vec_t;

  vec_t tbl [6];

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{8'h99, 1'b0, 8'h99, 8'h99, 8};
    tbl[1] = '{8'h01, 1'b0, 8'h01, 8'h80, 8};
    tbl[2] = '{8'hF0, 1'b1, 8'hF0, 8'h0F, 16};
    tbl[3] = '{8'h12, 1'b0, 8'h12, 8'h48, 8};
    tbl[4] = '{8'hC4, 1'b0, 8'hC4, 8'h23, 8};
    tbl[5] = '{8'hFF, 1'b1, 8'hFF, 8'hFF, 16};

    rst = 1'b0; in_data = '0; in_valid = 1'b0; bit_en = 1'b1;
    #1;
    chk("rst_dout", 0, 64'(o_dout), 64'(2'b10));
    chk("rst_dv", 0, 64'(o_dv), 64'(0));
    chk("rst_fs", 0, 64'(o_fs), 64'(0));
    chk("rst_busy", 0, 64'(o_busy), 64'(0));
    chk("rst_rdy", 0, 64'(o_rdy), 64'(0));
    @(posedge clk); #1; chk_on = 1'b1;
    @(posedge clk); #2; rst = 1'b1;
    @(posedge clk); #1;
    chk("rdy_after_release", 0, 64'(o_rdy), 64'(2'b11));

    // Single words, free-running and throttled
    for (int v = 0; v < 6; v++) begin
      wait_idle();
      fork
        send_seq(tbl[v].d, 8'h00, 8'h00, 1);
        collect(32, tbl[v].tog);
      join
      chk("tbl_msb_bits", v, sr[0][7:0], 64'(tbl[v].e_msb));
      chk("tbl_lsb_bits", v, sr[1][7:0], 64'(tbl[v].e_lsb));
      for (int i = 0; i < 2; i++) begin
        chk("tbl_nbits", i, 64'(nb[i]), 64'(8));
        chk("tbl_valid_cycles", i, 64'(vc[i]), 64'(tbl[v].e_vc));
        chk("tbl_contig", i, 64'(last[i] - first[i] + 1), 64'(vc[i]));
        chk("tbl_fs_mask", i, fsm[i], 64'h1);
        chk("tbl_busy_fall", i, 64'(lastbusy[i]), 64'(last[i]));
        chk("tbl_idle_dout", i, 64'(o_dout[i]), 64'(idle(i)));
      end
    end

    // Back-to-back pair and three-word backpressure
    wait_idle();
    fork
      send_seq(8'hA5, 8'h3C, 8'h00, 2);
      collect(40, 1'b0);
    join
    chk("b2b_msb", 0, sr[0][15:0], 64'hA53C);
    chk("b2b_lsb", 1, sr[1][15:0], 64'hA53C);
    for (int i = 0; i < 2; i++) begin
      chk("b2b_vc", i, 64'(vc[i]), 64'(16));
      chk("b2b_contig", i, 64'(last[i] - first[i] + 1), 64'(16));
      chk("b2b_fs", i, fsm[i], 64'h101);
    end

    wait_idle();
    fork
      send_seq(8'h11, 8'h22, 8'h33, 3);
      collect(50, 1'b0);
    join
    chk("bp_msb", 0, sr[0][23:0], 64'h112233);
    chk("bp_lsb", 1, sr[1][23:0], 64'h8844CC);
    for (int i = 0; i < 2; i++) begin
      chk("bp_nbits", i, 64'(nb[i]), 64'(24));
      chk("bp_contig", i, 64'(last[i] - first[i] + 1), 64'(24));
      chk("bp_fs", i, fsm[i], 64'h010101);
    end

    // Reset mid-frame with a word held
    wait_idle();
    in_data = 8'hFF; in_valid = 1'b1; bit_en = 1'b1;
    @(posedge clk); #1;
    in_data = 8'h81;
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_busy", 0, 64'(o_busy), 64'(2'b11));
    chk("pre_rst_rdy", 0, 64'(o_rdy), 64'(2'b00));
    #1 rst = 1'b0;
    #1;
    chk("mid_rst_dout", 0, 64'(o_dout), 64'(2'b10));
    chk("mid_rst_dv", 0, 64'(o_dv), 64'(0));
    chk("mid_rst_busy", 0, 64'(o_busy), 64'(0));
    chk("mid_rst_rdy", 0, 64'(o_rdy), 64'(0));
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    @(negedge clk);
    chk("post_rst_rdy", 0, 64'(o_rdy), 64'(2'b11));
    @(posedge clk); #1;
    collect(20, 1'b0);
    chk("post_rst_residual", 0, 64'(vc[0] + vc[1]), 64'(0));

    // Random traffic against the model, with occasional resets
    for (int c = 0; c < 600; c++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = 8'($urandom);
      bit_en   = ($urandom_range(0, 3) != 0);
      rst      = ($urandom_range(0, 80) != 0);
      @(posedge clk); #1;
    end
    rst = 1'b1; in_valid = 1'b0; bit_en = 1'b1;
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mealy_serial_feeder.md
Name: mealy_serial_feeder

Overview:
- Parallel-to-serial stage that sits directly upstream of the sequence-detector FSMs.
- Accepts DATA_W-bit words over a valid/ready handshake and emits them one bit per enabled clock on a serial line that drives the detector's `din`.
- Includes a one-word holding buffer, so consecutive words are serialized with zero idle bits between them.
- Frame markers are provided for debug and scoreboard alignment.

Parameters:
- DATA_W, 8: word width in bits; legal range 2..32.
- MSB_FIRST, 1: 1 = bit DATA_W-1 is sent first; 0 = bit 0 is sent first.
- IDLE_BIT, 0: level driven on `dout` while no word is being shifted.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset; 0 resets immediately, release is synchronous to clk.
- in_data  input  DATA_W  parallel word to serialize.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a word this cycle.
- bit_en  input  1  pacing strobe; the current bit is consumed and the shifter advances only on edges where bit_en=1. Tie to 1 for one bit per clk.
- dout  output  1  serial bit, connects to the detector's din.
- dout_valid  output  1  dout carries a data bit, not idle fill.
- frame_start  output  1  dout carries bit 0 of a word's transmission order.
- busy  output  1  shifting, or a word is held.

Behaviour:
- Storage: shift register sh[DATA_W-1:0], bit counter cnt (enough bits for DATA_W-1), holding register hold[DATA_W-1:0], flag hold_full, state in {IDLE, SHIFT}.
- Reset (reset=0, any time, including mid-frame):
  - state=IDLE, sh=0, hold=0, hold_full=0, cnt=0.
  - Outputs: dout=IDLE_BIT, dout_valid=0, frame_start=0, busy=0, in_ready=0.
  - The in-flight word and the held word are discarded; no partial bits are emitted after reset.
- in_ready = reset & ~hold_full. It depends only on flops and reset, never combinationally on in_valid or bit_en.
- Accept: on an edge where in_valid & in_ready, hold<=in_data and hold_full<=1.
  - in_data is ignored when in_ready=0.
  - Accept and hold-transfer can never occur on the same edge, because transfer requires hold_full=1.
- IDLE:
  - dout=IDLE_BIT, dout_valid=0.
  - If hold_full=1 at an edge: sh<=hold, hold_full<=0, cnt<=0, state<=SHIFT. The transfer does not require bit_en.
- SHIFT:
  - dout = sh[DATA_W-1] if MSB_FIRST, else sh[0]. dout_valid=1. frame_start=(cnt==0).
  - Edge with bit_en=0: nothing changes; the bit is held.
  - Edge with bit_en=1 and cnt<DATA_W-1: shift by one (left if MSB_FIRST, else right; vacated bit filled with 0), cnt<=cnt+1.
  - Edge with bit_en=1 and cnt==DATA_W-1 (last bit):
    - if hold_full: sh<=hold, hold_full<=0, cnt<=0, stay in SHIFT (zero-gap back-to-back);
    - else: state<=IDLE, cnt<=0.
- busy = (state==SHIFT) | hold_full.
- Latency: word accepted at edge N → first bit on dout in the cycle after edge N+1 (2 edges, independent of bit_en).
- Throughput: one word per DATA_W enabled bits. The hold buffer refills during shifting because DATA_W>=2.
- No framing, stop or idle bits are inserted between back-to-back words. The downstream detector sees one continuous stream, and matches across word boundaries are legal.
- Idle fill IDLE_BIT is visible on dout between non-contiguous words. dout_valid qualifies it.
- bit_en=1 while in IDLE has no effect.

Test Plan:
1. Single word, MSB_FIRST=1, bit_en=1: accept 0x99 at edge N.
   - In the cycles after edges N+1..N+8, dout = 1,0,0,1,1,0,0,1 with dout_valid=1 and frame_start=1 only in the first.
   - After that, dout=0 and dout_valid=0.
   - With the detector attached, its dout pulses for the 1001 matches in the stream.
2. Back-to-back: in_valid held with 0xA5 then 0x3C, bit_en=1.
   - 16 contiguous valid bits: 1010010100111100.
   - in_ready=0 for exactly the cycles hold_full=1.
   - frame_start=1 at bit 0 and at bit 8 only.
3. Throttle: bit_en toggles 1,0,1,0..., word 0xF0.
   - Each bit is held on dout for 2 cycles.
   - 16 cycles of dout_valid; sequence 1,1,1,1,0,0,0,0 each doubled.
4. MSB_FIRST=0, word 0x01: dout = 1 then seven 0s; busy falls the cycle after the last bit.
5. Reset mid-frame: accept 0xFF plus a held 0x81, assert reset after 3 bits.
   - dout=IDLE_BIT, dout_valid=0, busy=0, in_ready=0 immediately, without waiting for a clock.
   - After release, in_ready=1 at the next clock and no residual bits appear.
6. Backpressure: in_valid held continuously with 0x11, 0x22, 0x33 and bit_en=1.
   - Each word is accepted exactly once, in order.
   - 24 contiguous bits; in_ready is never high while hold_full=1.
